// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache between the CPU data port and external memory.
// Tags include the page, so page switches need no flush; inv/flush come from the memory control unit.
module data_cache_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PAGE_W = 7,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned OFF_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PAGE_W-1:0]        page,
  input  logic                     inv,
  input  logic                     flush,
  output logic                     req,
  output logic                     ready,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic                     cpu_rden,
  input  logic                     cpu_wren,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic [PAGE_W+ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_rd,
  output logic                     mem_wr,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int unsigned MA_W   = PAGE_W + ADDR_W;
  localparam int unsigned TAG_W  = MA_W - IDX_W - OFF_W;
  localparam int unsigned LINES  = 2 ** IDX_W;
  localparam int unsigned WORDS  = 2 ** (IDX_W + OFF_W);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WB       = 3'd1;
  localparam logic [2:0] S_FILL     = 3'd2;
  localparam logic [2:0] S_DONE     = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;
  localparam logic [2:0] S_FLUSH_WB = 3'd5;

  logic [2:0]        state_q, state_n;
  logic [OFF_W-1:0]  off_q, off_n;
  logic [IDX_W-1:0]  scan_q, scan_n;
  logic [TAG_W-1:0]  miss_tag_q, miss_tag_n;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_n;
  logic [MA_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n;
  logic              mem_rd_n, mem_wr_n;

  logic [DATA_W-1:0] data_q [WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q, dirty_q;

  logic [MA_W-1:0]   cpu_full;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  cpu_idx;
  logic [OFF_W-1:0]  cpu_off;
  logic              lookup, tag_hit, ack_rd, ack_wr;
  logic              fill_we, hit_we, line_set, clr_all;

  assign cpu_full  = {page, cpu_addr};
  assign cpu_tag   = cpu_full[MA_W-1 -: TAG_W];
  assign cpu_idx   = cpu_addr[OFF_W +: IDX_W];
  assign cpu_off   = cpu_addr[OFF_W-1:0];
  assign ack_rd    = mem_ack & mem_rd;
  assign ack_wr    = mem_ack & mem_wr;

  // CPU is only served in IDLE and never in a cycle carrying a control command
  assign lookup    = (state_q == S_IDLE) & (cpu_rden | cpu_wren) & ~inv & ~flush;
  assign tag_hit   = valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
  assign cpu_ready = lookup & tag_hit;
  assign cpu_rdata = cpu_ready ? data_q[{cpu_idx, cpu_off}] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n     = state_q;
    off_n       = off_q;
    scan_n      = scan_q;
    miss_tag_n  = miss_tag_q;
    miss_idx_n  = miss_idx_q;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_rd_n    = mem_rd;
    mem_wr_n    = mem_wr;
    fill_we     = 1'b0;
    hit_we      = 1'b0;
    line_set    = 1'b0;
    clr_all     = 1'b0;
    if (inv) begin
      state_n  = S_DONE;
      mem_rd_n = 1'b0;
      mem_wr_n = 1'b0;
      clr_all  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            state_n = S_FLUSH;
            scan_n  = '0;
          end else if (lookup) begin
            if (tag_hit) begin
              hit_we = cpu_wren;
            end else begin
              miss_tag_n = cpu_tag;
              miss_idx_n = cpu_idx;
              off_n      = '0;
              if (valid_q[cpu_idx] & dirty_q[cpu_idx]) begin
                state_n     = S_WB;
                mem_wr_n    = 1'b1;
                mem_addr_n  = {tag_q[cpu_idx], cpu_idx, OFF_W'(0)};
                mem_wdata_n = data_q[{cpu_idx, OFF_W'(0)}];
              end else begin
                state_n    = S_FILL;
                mem_rd_n   = 1'b1;
                mem_addr_n = {cpu_tag, cpu_idx, OFF_W'(0)};
              end
            end
          end
        end
        S_WB: begin
          if (ack_wr) begin
            off_n = off_q + OFF_W'(1);
            if (off_q == '1) begin
              state_n    = S_FILL;
              mem_wr_n   = 1'b0;
              mem_rd_n   = 1'b1;
              mem_addr_n = {miss_tag_q, miss_idx_q, OFF_W'(0)};
            end else begin
              mem_addr_n  = {tag_q[miss_idx_q], miss_idx_q, off_n};
              mem_wdata_n = data_q[{miss_idx_q, off_n}];
            end
          end
        end
        S_FILL: begin
          if (ack_rd) begin
            fill_we = 1'b1;
            off_n   = off_q + OFF_W'(1);
            if (off_q == '1) begin
              state_n  = S_DONE;
              mem_rd_n = 1'b0;
              line_set = 1'b1;
            end else begin
              mem_addr_n = {miss_tag_q, miss_idx_q, off_n};
            end
          end
        end
        S_DONE: begin
          if (flush) begin
            state_n = S_FLUSH;
            scan_n  = '0;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (valid_q[scan_q] & dirty_q[scan_q]) begin
            state_n     = S_FLUSH_WB;
            off_n       = '0;
            mem_wr_n    = 1'b1;
            mem_addr_n  = {tag_q[scan_q], scan_q, OFF_W'(0)};
            mem_wdata_n = data_q[{scan_q, OFF_W'(0)}];
          end else begin
            scan_n = scan_q + IDX_W'(1);
            if (scan_q == '1) begin
              state_n = S_DONE;
              clr_all = 1'b1;
            end
          end
        end
        S_FLUSH_WB: begin
          if (ack_wr) begin
            off_n = off_q + OFF_W'(1);
            if (off_q == '1) begin
              mem_wr_n = 1'b0;
              scan_n   = scan_q + IDX_W'(1);
              if (scan_q == '1) begin
                state_n = S_DONE;
                clr_all = 1'b1;
              end else begin
                state_n = S_FLUSH;
              end
            end else begin
              mem_addr_n  = {tag_q[scan_q], scan_q, off_n};
              mem_wdata_n = data_q[{scan_q, off_n}];
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Burst bookkeeping and registered memory/control-unit outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q      <= '0;
      scan_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      req        <= 1'b0;
      ready      <= 1'b0;
    end else begin
      off_q      <= off_n;
      scan_q     <= scan_n;
      miss_tag_q <= miss_tag_n;
      miss_idx_q <= miss_idx_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_rd     <= mem_rd_n;
      mem_wr     <= mem_wr_n;
      req        <= (state_n != S_IDLE);
      ready      <= (state_n == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (line_set) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (hit_we) dirty_q[cpu_idx] <= 1'b1;
    end
  end

  // Data and tag storage need no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (fill_we)  data_q[{miss_idx_q, off_q}]   <= mem_rdata;
    if (hit_we)   data_q[{cpu_idx, cpu_off}]    <= cpu_wdata;
    if (line_set) tag_q[miss_idx_q]             <= miss_tag_q;
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Directed bench for data_cache_ctrl with a 1-cycle-ack external memory model and access logs.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  page;
  logic        inv, flush;
  logic        req, ready;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_rden, cpu_wren;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic        ack_en, ack_force;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_log[$];
  logic [15:0] wr_addr_log[$];
  logic [15:0] wr_data_log[$];
  int          ready_cnt = 0;
  int          overlap_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  data_cache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .page(page), .inv(inv), .flush(flush),
    .req(req), .ready(ready), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rden(cpu_rden), .cpu_wren(cpu_wren), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  assign mem_ack   = (ack_en & (mem_rd | mem_wr)) | ack_force;
  assign mem_rdata = mem[mem_addr];

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  always @(posedge clk) begin
    if (mem_ack && mem_rd) rd_log.push_back(mem_addr);
    if (mem_ack && mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (ready) ready_cnt++;
    if (mem_rd && mem_wr) overlap_cnt++;
  end

  task automatic clear_logs();
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    ready_cnt = 0;
  endtask

  task automatic cpu_access(input logic wr, input logic [8:0] a, input logic [15:0] wd,
                            output logic [15:0] rd, output int cyc);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = wd; cpu_wren = wr; cpu_rden = !wr; cyc = 0;
    #1;
    while (!cpu_ready && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL access_timeout addr=%h got cpu_ready=%b want 1", a, cpu_ready);
    end
    rd = cpu_rdata;
    @(posedge clk); #1;
    cpu_rden = 1'b0; cpu_wren = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; page = '0; inv = 0; flush = 0; cpu_addr = '0; cpu_wdata = '0;
    cpu_rden = 0; cpu_wren = 0; ack_en = 1; ack_force = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req, ready, cpu_ready, mem_rd, mem_wr} !== 5'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 16'h0 || cpu_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b rdy=%b cr=%b rd=%b wr=%b ma=%h wd=%h crd=%h want all 0",
               req, ready, cpu_ready, mem_rd, mem_wr, mem_addr, mem_wdata, cpu_rdata);
    end
    rst_n = 1'b1;
    clear_logs();
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    checks++;
    if ({req, mem_rd, mem_wr} !== 3'b0 || rd_log.size() != 0) begin
      errors++;
      $display("FAIL stray_ack got req=%b rd=%b wr=%b reads=%0d want 0", req, mem_rd, mem_wr, rd_log.size());
    end
  endtask

  task automatic test_cold_read();
    logic [15:0] rd; int cyc;
    page = 7'h05; clear_logs();
    cpu_access(1'b0, 9'h012, 16'h0, rd, cyc);
    checks++;
    if (rd_log.size() != 4) begin
      errors++; $display("FAIL cold_read_count got %0d want 4", rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_log[i] !== 16'h0A10 + 16'(i)) begin
          errors++; $display("FAIL cold_read_addr%0d got %h want %h", i, rd_log[i], 16'h0A10 + 16'(i));
        end
      end
    end
    checks++;
    if (rd !== memval(16'h0A12)) begin
      errors++; $display("FAIL cold_read_data got %h want %h", rd, memval(16'h0A12));
    end
    checks++;
    if (cyc != 6) begin errors++; $display("FAIL cold_read_latency got %0d want 6", cyc); end
    checks++;
    if (ready_cnt != 1) begin errors++; $display("FAIL cold_read_ready got %0d want 1", ready_cnt); end
  endtask

  task automatic test_conflict_wb();
    logic [15:0] rd; int cyc;
    logic [15:0] exp_d [4];
    page = 7'h05;
    cpu_access(1'b1, 9'h012, 16'h1234, rd, cyc);
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL write_hit_latency got %0d want 0", cyc); end
    clear_logs();
    cpu_access(1'b0, 9'h112, 16'h0, rd, cyc);
    exp_d[0] = memval(16'h0A10); exp_d[1] = memval(16'h0A11);
    exp_d[2] = 16'h1234;         exp_d[3] = memval(16'h0A13);
    checks++;
    if (wr_addr_log.size() != 4 || rd_log.size() != 4) begin
      errors++; $display("FAIL wb_counts got wr=%0d rd=%0d want 4/4", wr_addr_log.size(), rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr_log[i] !== 16'h0A10 + 16'(i) || wr_data_log[i] !== exp_d[i] ||
            rd_log[i] !== 16'h0B10 + 16'(i)) begin
          errors++;
          $display("FAIL wb_word%0d got wa=%h wd=%h ra=%h want %h %h %h", i, wr_addr_log[i],
                   wr_data_log[i], rd_log[i], 16'h0A10 + 16'(i), exp_d[i], 16'h0B10 + 16'(i));
        end
      end
    end
    checks++;
    if (rd !== memval(16'h0B12)) begin errors++; $display("FAIL conflict_data got %h want %h", rd, memval(16'h0B12)); end
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL dirty_latency got %0d want 10", cyc); end
  endtask

  task automatic test_page_alias();
    logic [15:0] rd; int cyc;
    page = 7'h05;
    cpu_access(1'b0, 9'h012, 16'h0, rd, cyc);
    checks++;
    if (rd !== 16'h1234) begin errors++; $display("FAIL refetch_written got %h want 1234", rd); end
    page = 7'h06; clear_logs();
    cpu_access(1'b0, 9'h012, 16'h0, rd, cyc);
    checks++;
    if (cyc != 6 || rd_log.size() != 4 || rd_log[0] !== 16'h0C10) begin
      errors++; $display("FAIL page_alias got cyc=%0d n=%0d want cyc 6 n 4 first 0C10", cyc, rd_log.size());
    end
    checks++;
    if (rd !== memval(16'h0C12)) begin errors++; $display("FAIL page_alias_data got %h want %h", rd, memval(16'h0C12)); end
  endtask

  task automatic test_flush();
    logic [15:0] rd; int cyc; int n;
    logic [15:0] exp_a [8];
    logic [15:0] exp_d [8];
    page = 7'h06;
    cpu_access(1'b1, 9'h005, 16'hBEEF, rd, cyc);
    cpu_access(1'b1, 9'h01A, 16'hCAFE, rd, cyc);
    for (int i = 0; i < 4; i++) begin
      exp_a[i] = 16'h0C04 + 16'(i); exp_d[i] = memval(exp_a[i]);
      exp_a[i+4] = 16'h0C18 + 16'(i); exp_d[i+4] = memval(exp_a[i+4]);
    end
    exp_d[1] = 16'hBEEF; exp_d[6] = 16'hCAFE;
    clear_logs();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; n = 1;
    while (!ready && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_addr_log.size() != 8) begin
      errors++; $display("FAIL flush_wr_count got %0d want 8", wr_addr_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_addr_log[i] !== exp_a[i] || wr_data_log[i] !== exp_d[i]) begin
          errors++; $display("FAIL flush_word%0d got %h/%h want %h/%h", i, wr_addr_log[i],
                             wr_data_log[i], exp_a[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (ready_cnt != 1) begin errors++; $display("FAIL flush_ready got %0d want 1", ready_cnt); end
    cpu_access(1'b0, 9'h01A, 16'h0, rd, cyc);
    checks++;
    if (cyc != 6 || rd !== 16'hCAFE) begin
      errors++; $display("FAIL flush_invalidated got cyc=%0d data=%h want 6 CAFE", cyc, rd);
    end
    clear_logs();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; n = 1;
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL flush_req got %b want 1", req); end
    while (!ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n != 9 || wr_addr_log.size() != 0) begin
      errors++; $display("FAIL clean_flush_time got %0d cycles %0d writes want 9 0", n, wr_addr_log.size());
    end
  endtask

  task automatic test_inv_mid_fill();
    logic [15:0] rd; int cyc; int n;
    page = 7'h06; clear_logs();
    @(negedge clk); cpu_addr = 9'h030; cpu_rden = 1'b1; n = 0;
    while (rd_log.size() < 2 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (mem_rd !== 1'b1 || rd_log.size() != 2) begin
      errors++; $display("FAIL inv_setup got rd=%b n=%0d want 1 2", mem_rd, rd_log.size());
    end
    inv = 1'b1; cpu_rden = 1'b0;
    @(negedge clk);
    inv = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || ready !== 1'b1 || req !== 1'b1) begin
      errors++; $display("FAIL inv_abort got rd=%b ready=%b req=%b want 0 1 1", mem_rd, ready, req);
    end
    clear_logs();
    cpu_access(1'b0, 9'h030, 16'h0, rd, cyc);
    checks++;
    if (cyc != 6 || rd_log.size() != 4 || rd_log[0] !== 16'h0C30 || rd !== memval(16'h0C30)) begin
      errors++; $display("FAIL inv_refill got cyc=%0d n=%0d data=%h want 6 4 %h", cyc, rd_log.size(), rd, memval(16'h0C30));
    end
  endtask

  task automatic test_reset_in_wb();
    logic [15:0] rd; int cyc;
    page = 7'h06;
    cpu_access(1'b1, 9'h031, 16'h7777, rd, cyc);
    ack_en = 1'b0;
    @(negedge clk); cpu_addr = 9'h010; cpu_rden = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h0C30 || mem_wdata !== memval(16'h0C30)) begin
      errors++; $display("FAIL wb_start got wr=%b a=%h d=%h want 1 0C30 %h", mem_wr, mem_addr, mem_wdata, memval(16'h0C30));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req, ready, cpu_ready, mem_rd, mem_wr} !== 5'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 16'h0 || cpu_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_in_wb got req=%b rdy=%b cr=%b wr=%b ma=%h want all 0",
                         req, ready, cpu_ready, mem_wr, mem_addr);
    end
    @(negedge clk);
    cpu_rden = 1'b0; ack_en = 1'b1; rst_n = 1'b1;
    clear_logs();
    cpu_access(1'b0, 9'h031, 16'h0, rd, cyc);
    checks++;
    if (cyc != 6 || rd !== memval(16'h0C31) || wr_addr_log.size() != 0) begin
      errors++; $display("FAIL post_reset_miss got cyc=%0d data=%h wr=%0d want 6 %h 0", cyc, rd, wr_addr_log.size(), memval(16'h0C31));
    end
    checks++;
    if (overlap_cnt != 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = memval(16'(i));
    test_reset();
    test_cold_read();
    test_conflict_wb();
    test_page_alias();
    test_flush();
    test_inv_mid_fill();
    test_reset_in_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
